gray_step_checker: RTL
======================

Name: gray_step_checker

Overview:
Downstream consumer of the 3-bit gray counter (Output/Overflow/En). Each cycle it samples the counter's gray value, decodes it to binary and counts wrap-arounds. It checks every step against the gray-counter contract and latches the first violation with a sticky error code. It sits between the counter and any binary-consuming logic, and also serves as a self-checking monitor in benches.

Parameters:
WIDTH, 3, gray/binary width; must match the counter
CNTW, 4, width of wrap counter (saturating)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
En  input  1  same enable that drives the counter
Gray  input  WIDTH  counter Output
Ovf  input  1  counter Overflow (sticky flag in the counter)
Bin  output  WIDTH  registered binary decode of Gray
Valid  output  1  Bin/checks meaningful (state TRACK or ERROR)
Err  output  1  sticky error flag
Err_code  output  3  first error seen; 0 = none
Wrap_cnt  output  CNTW  number of max->0 wraps seen, saturating

Behaviour:
- One clock (Clk). Reset is synchronous and active-high. All state changes occur on the rising Clk edge.
- Reset=1 at an edge: state=IDLE; Bin=0, Valid=0, Err=0, Err_code=0, Wrap_cnt=0; prev regs (prev_gray, prev_bin, en_d, ovf_d) cleared. Reset mid-operation behaves identically, including clearing ERROR.
- Decode: bin[W-1]=gray[W-1]; bin[i]=bin[i+1]^gray[i]. Bin is registered, so it has 1-cycle latency from Gray.
- States:
  - IDLE: first non-reset edge captures Gray/En/Ovf into prev regs and loads Bin. Sets Valid=1. Goes to TRACK. No checks in IDLE.
  - TRACK: each edge computes d = popcount(Gray ^ prev_gray) and nb = decode(Gray). Step expected iff en_d=1 (En at the previous edge, aligned to the counter's update).
  - ERROR: sticky until Reset. Bin/Wrap_cnt keep updating; Err_code frozen; no further checks.
- Error codes, checked in TRACK:
  - 1 multi-bit: d>1
  - 2 wrong direction: d==1 and nb != prev_bin+1 (mod 2^WIDTH)
  - 4 moved while disabled: en_d=0 and d!=0
  - 5 stalled while enabled: en_d=1 and d==0
  - 3 overflow violation: ovf_d=1 and Ovf=0 (sticky flag dropped), or Ovf rises (ovf_d=0, Ovf=1) with neither a wrap this edge nor Wrap_cnt>0
- Simultaneous errors: lowest non-zero code wins, priority 1>2>3>4>5. On any error: Err=1, Err_code=code, state->ERROR on the same edge.
- Wrap: prev_bin==2^WIDTH-1 and nb==0 with d==1 -> Wrap_cnt+1, saturating at 2^CNTW-1.
- prev regs update every non-reset edge in TRACK and ERROR.

Decomposition:
- gray_pkg: state encoding (IDLE/TRACK/ERROR); Err_code constants ERR_NONE=0, ERR_MULTI=1, ERR_DIR=2, ERR_OVF=3, ERR_MOVE_DIS=4, ERR_STALL_EN=5.
- Sub-module gray2bin (parameterised WIDTH, purely combinational), instantiated twice (current and for the wrap check if needed). popcount stays inline.

Test Plan:
- Reset=1 two cycles, then Gray=000, En=1, counting 000,001,011,010,110,111,101,100,000 -> Bin 0..7,0 one cycle late; Valid=1 after the first post-reset edge; Wrap_cnt=1; Err=0.
- Same sequence with Ovf rising on the 100->000 edge and held 1 -> Err=0. Then force Ovf=0 -> Err=1, Err_code=3 next edge.
- TRACK at Gray=001, inject 010 (d=2) -> Err=1, Err_code=1; subsequent legal steps leave Err_code=1.
- From 011, inject 001 (backward, d=1) -> Err_code=2. Separately, En=0 held while Gray steps 001->011 -> Err_code=4.
- En=1 with Gray held at 011 for 2 edges -> Err_code=5. Then Reset=1 for one edge -> all outputs 0, state IDLE; resume legal counting -> Err=0.
- WIDTH=3, CNTW=2: run 5 full wraps -> Wrap_cnt saturates at 3, Err=0.

Source files
------------

// File: rtl/gray_step_checker_pkg.sv
// Shared types for the gray step checker: checker state encoding and error codes.
package gray_step_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_MULTI    = 3'd1;
    localparam logic [2:0] ERR_DIR      = 3'd2;
    localparam logic [2:0] ERR_OVF      = 3'd3;
    localparam logic [2:0] ERR_MOVE_DIS = 3'd4;
    localparam logic [2:0] ERR_STALL_EN = 3'd5;

endpackage

// File: rtl/gray_step_checker_if.sv
// Signal bundle between a gray counter (plus its enable) and the step checker.
interface gray_step_checker_if #(
    parameter int WIDTH = 3,
    parameter int CNTW  = 4
);
    logic             En;
    logic [WIDTH-1:0] Gray;
    logic             Ovf;
    logic [WIDTH-1:0] Bin;
    logic             Valid;
    logic             Err;
    logic [2:0]       Err_code;
    logic [CNTW-1:0]  Wrap_cnt;

    modport master (
        output En, Gray, Ovf,
        input  Bin, Valid, Err, Err_code, Wrap_cnt
    );

    modport slave (
        input  En, Gray, Ovf,
        output Bin, Valid, Err, Err_code, Wrap_cnt
    );
endinterface

// File: rtl/gray_step_checker_gray2bin.sv
// Combinational gray-to-binary decoder.
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of its gray bit and every gray bit above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_step_checker.sv
// Monitors a gray counter: decodes it, counts wraps and latches the first contract violation.
module gray_step_checker
    import gray_step_checker_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNTW  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    gray_step_checker_if.slave bus
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   ONE_STEP = CW'(1'b1);
    localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};
    localparam logic [CNTW-1:0] WRAP_MAX = {CNTW{1'b1}};

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] prev_gray_r;
    logic [WIDTH-1:0] prev_bin_s;
    logic [WIDTH-1:0] nb_s;
    logic [WIDTH-1:0] diff_s;
    logic [CW-1:0]    d_s;
    logic             wrap_s;
    logic [2:0]       code_s;
    logic             en_d_r;
    logic             ovf_d_r;
    logic [WIDTH-1:0] bin_r;
    logic             valid_r;
    logic             err_r;
    logic [2:0]       code_r;
    logic [CNTW-1:0]  wrap_r;

    // The previous binary value is re-derived from the stored gray word.
    gray2bin #(.WIDTH(WIDTH)) u_cur  (.gray(bus.Gray),   .bin(nb_s));
    gray2bin #(.WIDTH(WIDTH)) u_prev (.gray(prev_gray_r), .bin(prev_bin_s));

    // Hamming distance between the current and previous gray words.
    always_comb begin
        diff_s = bus.Gray ^ prev_gray_r;
        d_s    = {CW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            d_s = d_s + CW'(diff_s[i]);
        end
    end

    // Detect a legal max->0 step.
    always_comb begin
        if ((prev_bin_s == BIN_MAX) && (nb_s == {WIDTH{1'b0}}) && (d_s == ONE_STEP)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Classify the step; the ordering of the chain gives the lowest code priority.
    always_comb begin
        code_s = ERR_NONE;
        if (d_s > ONE_STEP) begin
            code_s = ERR_MULTI;
        end else if ((d_s == ONE_STEP) && (nb_s != (prev_bin_s + BIN_ONE))) begin
            code_s = ERR_DIR;
        end else if ((ovf_d_r && !bus.Ovf) ||
                     (!ovf_d_r && bus.Ovf && !wrap_s && (wrap_r == {CNTW{1'b0}}))) begin
            code_s = ERR_OVF;
        end else if (!en_d_r && (d_s != {CW{1'b0}})) begin
            code_s = ERR_MOVE_DIS;
        end else if (en_d_r && (d_s == {CW{1'b0}})) begin
            code_s = ERR_STALL_EN;
        end else begin
            code_s = ERR_NONE;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = ST_TRACK;
            ST_TRACK: begin
                if (code_s != ERR_NONE) begin
                    state_next_s = ST_ERROR;
                end else begin
                    state_next_s = ST_TRACK;
                end
            end
            ST_ERROR: state_next_s = ST_ERROR;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // History, decode, sticky error and saturating wrap counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_gray_r <= {WIDTH{1'b0}};
            en_d_r      <= 1'b0;
            ovf_d_r     <= 1'b0;
            bin_r       <= {WIDTH{1'b0}};
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
            code_r      <= ERR_NONE;
            wrap_r      <= {CNTW{1'b0}};
        end else begin
            prev_gray_r <= bus.Gray;
            en_d_r      <= bus.En;
            ovf_d_r     <= bus.Ovf;
            bin_r       <= nb_s;
            valid_r     <= 1'b1;
            if ((state_r == ST_TRACK) && (code_s != ERR_NONE)) begin
                err_r  <= 1'b1;
                code_r <= code_s;
            end
            if ((state_r != ST_IDLE) && wrap_s && (wrap_r != WRAP_MAX)) begin
                wrap_r <= wrap_r + CNTW'(1'b1);
            end
        end
    end

    assign bus.Bin      = bin_r;
    assign bus.Valid    = valid_r;
    assign bus.Err      = err_r;
    assign bus.Err_code = code_r;
    assign bus.Wrap_cnt = wrap_r;

endmodule
